// File: rtl/wb_stage_reg.sv
// wb_stage_reg: writeback source select with RV32I load formatting, registered regfile write and retire counter
module wb_stage_reg #(
  parameter int XLEN    = 32,
  parameter int NUM_SRC = 4,
  parameter int SEL_W   = $clog2(NUM_SRC),
  parameter int CNT_W   = 64
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    valid_i,
  input  logic                    stall_i,
  input  logic                    flush_i,
  input  logic [NUM_SRC*XLEN-1:0] src_i,
  input  logic [SEL_W-1:0]        sel_i,
  input  logic [2:0]              ld_funct3_i,
  input  logic [1:0]              addr_lo_i,
  input  logic [4:0]              rd_i,
  input  logic                    regwen_i,
  output logic [XLEN-1:0]         data_o,
  output logic [4:0]              rd_o,
  output logic                    regwen_o,
  output logic                    valid_o,
  output logic                    misalign_o,
  output logic [CNT_W-1:0]        retire_cnt_o
);
  logic [XLEN-1:0]  w_word, w_fmt, w_sel;
  logic [7:0]       w_b;
  logic [15:0]      w_h;
  logic             w_mis;
  logic [XLEN-1:0]  r_data;
  logic [4:0]       r_rd;
  logic             r_regwen, r_valid, r_mis;
  logic [CNT_W-1:0] r_cnt;
  assign w_word = src_i[XLEN-1:0];
  assign w_b    = w_word[8*addr_lo_i +: 8];
  assign w_h    = w_word[16*addr_lo_i[1] +: 16];
  always_comb begin
    w_fmt = ld_funct3_i == 3'b000 ? XLEN'($signed(w_b)) :
            ld_funct3_i == 3'b100 ? XLEN'(w_b) :
            ld_funct3_i == 3'b001 ? XLEN'($signed(w_h)) :
            ld_funct3_i == 3'b101 ? XLEN'(w_h) :
            ld_funct3_i == 3'b010 ? XLEN'($signed(w_word[31:0])) : w_word;
    w_mis = sel_i == '0 && (ld_funct3_i[1:0] == 2'b01 ? addr_lo_i[0] :
            ld_funct3_i == 3'b010 ? |addr_lo_i : 1'b0);
    w_sel = int'(sel_i) >= NUM_SRC ? '0 :
            sel_i == '0 ? w_fmt : src_i[int'(sel_i)*XLEN +: XLEN];
  end
  // flush kills the instruction but leaves data/rd untouched
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_data   <= '0;
      r_rd     <= '0;
      r_regwen <= 1'b0;
      r_valid  <= 1'b0;
      r_mis    <= 1'b0;
      r_cnt    <= '0;
    end else if (flush_i) begin
      r_regwen <= 1'b0;
      r_valid  <= 1'b0;
      r_mis    <= 1'b0;
    end else if (!stall_i) begin
      r_data   <= w_sel;
      r_rd     <= rd_i;
      r_regwen <= regwen_i & valid_i & (rd_i != 5'd0) & ~w_mis;
      r_valid  <= valid_i;
      r_mis    <= w_mis & valid_i;
      r_cnt    <= r_cnt + CNT_W'(valid_i & ~w_mis);
    end
  end
  assign data_o       = r_data;
  assign rd_o         = r_rd;
  assign regwen_o     = r_regwen;
  assign valid_o      = r_valid;
  assign misalign_o   = r_mis;
  assign retire_cnt_o = r_cnt;
endmodule

// File: tb/tb_wb_stage_reg.sv
// tb_wb_stage_reg: random and directed checks of wb_stage_reg against a behavioural model
module tb_wb_stage_reg;
  logic         clk = 1'b0;
  logic         rst, valid, stall, flush, regwen;
  logic [127:0] src;
  logic [1:0]   sel, o;
  logic [2:0]   f;
  logic [4:0]   rd;
  logic [31:0]  d0, d1;
  logic [4:0]   rd0, rd1;
  logic         rw0, rw1, v0, v1, m0, m1;
  logic [63:0]  c0;
  logic [3:0]   c1;
  int           n_tests = 0, n_fail = 0;
  logic [31:0]  e_d[2];
  logic [4:0]   e_rd[2];
  logic         e_rw[2], e_v[2], e_m[2];
  logic [63:0]  e_c[2];

  always #5 clk = ~clk;

  wb_stage_reg dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .stall_i(stall), .flush_i(flush),
    .src_i(src), .sel_i(sel), .ld_funct3_i(f), .addr_lo_i(o), .rd_i(rd), .regwen_i(regwen),
    .data_o(d0), .rd_o(rd0), .regwen_o(rw0), .valid_o(v0), .misalign_o(m0), .retire_cnt_o(c0)
  );

  wb_stage_reg #(.NUM_SRC(3), .CNT_W(4)) dut_w (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .stall_i(stall), .flush_i(flush),
    .src_i(src[95:0]), .sel_i(sel), .ld_funct3_i(f), .addr_lo_i(o), .rd_i(rd), .regwen_i(regwen),
    .data_o(d1), .rd_o(rd1), .regwen_o(rw1), .valid_o(v1), .misalign_o(m1), .retire_cnt_o(c1)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_val(input int s, input int ns, input logic [127:0] srcs,
                                          input int fn, input int off, output logic mis);
    logic [31:0] w = srcs[31:0];
    int b, h;
    mis = 1'b0;
    if (s >= ns) return 32'd0;
    if (s != 0) return 32'((srcs >> (32 * s)) & 128'hFFFF_FFFF);
    b = int'((w >> (8 * off)) & 32'hFF);
    h = int'((w >> (16 * (off / 2))) & 32'hFFFF);
    case (fn)
      0: return 32'(b > 127 ? b - 256 : b);
      4: return 32'(b);
      1: begin mis = (off % 2) != 0; return 32'(h > 32767 ? h - 65536 : h); end
      5: begin mis = (off % 2) != 0; return 32'(h); end
      2: begin mis = off != 0; return w; end
      default: return w;
    endcase
  endfunction

  task automatic step();
    for (int k = 0; k < 2; k++) begin
      logic [31:0] val;
      logic mis;
      val = ref_val(int'(sel), k ? 3 : 4, src, int'(f), int'(o), mis);
      if (rst) begin
        e_d[k] = 0; e_rd[k] = 0; e_rw[k] = 0; e_v[k] = 0; e_m[k] = 0; e_c[k] = 0;
      end else if (flush) begin
        e_rw[k] = 0; e_v[k] = 0; e_m[k] = 0;
      end else if (!stall) begin
        e_d[k]  = val;
        e_rd[k] = rd;
        e_rw[k] = regwen && valid && rd != 0 && !mis;
        e_v[k]  = valid;
        e_m[k]  = mis && valid;
        if (valid && !mis) e_c[k] = k ? (e_c[k] + 1) % 16 : e_c[k] + 1;
      end
    end
    @(posedge clk);
    #1;
    check("d0", d0, e_d[0]);   check("d1", d1, e_d[1]);
    check("rd0", rd0, e_rd[0]); check("rd1", rd1, e_rd[1]);
    check("rw0", rw0, e_rw[0]); check("rw1", rw1, e_rw[1]);
    check("v0", v0, e_v[0]);   check("v1", v1, e_v[1]);
    check("m0", m0, e_m[0]);   check("m1", m1, e_m[1]);
    check("c0", c0, e_c[0]);   check("c1", c1, e_c[1]);
  endtask

  task automatic rand_in();
    src    = {$urandom, $urandom, $urandom, $urandom};
    sel    = 2'($urandom);
    f      = 3'($urandom);
    o      = 2'($urandom);
    rd     = 5'($urandom);
    regwen = 1'($urandom);
    valid  = 1'($urandom);
  endtask

  task automatic ctl(input logic r, input logic s, input logic fl);
    rst = r; stall = s; flush = fl;
  endtask

  task automatic op(input logic [1:0] s, input logic [2:0] fn, input logic [1:0] off,
                    input logic [4:0] d, input logic we, input logic v);
    sel = s; f = fn; o = off; rd = d; regwen = we; valid = v;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      e_d[k] = 0; e_rd[k] = 0; e_rw[k] = 0; e_v[k] = 0; e_m[k] = 0; e_c[k] = 0;
    end
    rand_in();
    ctl(1, 0, 0);
    #1;
    repeat (2) begin rand_in(); step(); end
    check("rst_data", d0, 0); check("rst_cnt", c0, 0); check("rst_valid", v0, 0);

    ctl(0, 0, 0);
    rand_in();
    src[63:32] = 32'h1234_5678;
    op(1, 0, 0, 5, 1, 1);
    step();
    check("alu_data", d0, 32'h1234_5678); check("alu_rd", rd0, 5);
    check("alu_we", rw0, 1); check("alu_cnt", c0, 1);

    src[31:0] = 32'h80FF_7F01;
    op(0, 3'b000, 2, 7, 1, 1); step(); check("lb", d0, 32'hFFFF_FFFF);
    op(0, 3'b100, 3, 7, 1, 1); step(); check("lbu", d0, 32'h0000_0080);
    op(0, 3'b001, 0, 7, 1, 1); step(); check("lh", d0, 32'h0000_7F01);
    op(0, 3'b101, 2, 7, 1, 1); step(); check("lhu", d0, 32'h0000_80FF);
    op(0, 3'b010, 1, 7, 1, 1); step();
    check("lw_mis", m0, 1); check("lw_we", rw0, 0); check("lw_cnt", c0, 5);

    op(1, 0, 0, 0, 1, 1); step();
    check("x0_we", rw0, 0); check("x0_valid", v0, 1); check("x0_cnt", c0, 6);

    ctl(0, 1, 0);
    repeat (3) begin rand_in(); step(); end
    check("stall_cnt", c0, 6);
    ctl(0, 1, 1); rand_in(); valid = 1; regwen = 1; rd = 9; step();
    check("flush_valid", v0, 0); check("flush_we", rw0, 0);

    ctl(1, 1, 0); rand_in(); step();
    check("rst_in_stall", c0, 0);

    for (int i = 0; i < 400; i++) begin
      rand_in();
      valid = ($urandom % 4) != 0;
      ctl(($urandom % 50) == 0, ($urandom % 5) == 0, ($urandom % 10) == 0);
      step();
    end

    ctl(1, 0, 0); rand_in(); step();
    ctl(0, 0, 0);
    repeat (17) begin rand_in(); op(1, 0, 0, 3, 1, 1); step(); end
    check("wrap", c1, 1);
    rand_in(); op(3, 0, 0, 4, 1, 1); step();
    check("sel_oob", d1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
